// File: rtl/reg_file_if.sv
// ============================================================================
// Module      : reg_file_if
// Description : Writeback, read-port and status signals of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              write;
    logic [ADDR_W-1:0] writing_address;
    logic [DATA_W-1:0] write_inp;
    logic [ADDR_W-1:0] rs_add;
    logic [ADDR_W-1:0] rt_add;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              ready;

    modport master (
        output write,
        output writing_address,
        output write_inp,
        output rs_add,
        output rt_add,
        input  rs_data,
        input  rt_data,
        input  ready
    );

    modport slave (
        input  write,
        input  writing_address,
        input  write_inp,
        input  rs_add,
        input  rt_add,
        output rs_data,
        output rt_data,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : MIPS general-purpose register file, two registered read ports,
//               r0 hardwired to zero, post-reset clearing sweep before ready.
//               Optional macro RF_BYPASS_EN: same-cycle write-through to reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    reg_file_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] c_LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

    state_t            r_state;
    logic [ADDR_W:0]   r_init_cnt;
    logic              r_ready;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    state_t            w_state_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_ready_nxt;
    logic              w_clr_en;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rs_nxt;
    logic [DATA_W-1:0] w_rt_nxt;
    logic              w_wr_req;
    logic              w_rs_hit;
    logic              w_rt_hit;
    logic [DATA_W-1:0] w_rs_rd;
    logic [DATA_W-1:0] w_rt_rd;

    // A write request that would actually land (r0 is never written)
    assign w_wr_req = bus.write && (bus.writing_address != '0);

`ifdef RF_BYPASS_EN
    assign w_rs_hit = w_wr_req && (bus.writing_address == bus.rs_add);
    assign w_rt_hit = w_wr_req && (bus.writing_address == bus.rt_add);
`else
    assign w_rs_hit = 1'b0;
    assign w_rt_hit = 1'b0;
`endif

    assign w_rs_rd = (bus.rs_add == '0) ? '0 :
                     w_rs_hit           ? bus.write_inp : r_regs[bus.rs_add];
    assign w_rt_rd = (bus.rt_add == '0) ? '0 :
                     w_rt_hit           ? bus.write_inp : r_regs[bus.rt_add];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_init_cnt;
        w_ready_nxt = r_ready;
        w_clr_en    = 1'b0;
        w_wr_en     = 1'b0;
        w_rs_nxt    = '0;
        w_rt_nxt    = '0;
        case (r_state)
            ST_INIT: begin
                w_clr_en    = 1'b1;
                w_cnt_nxt   = r_init_cnt + 1'b1;
                w_ready_nxt = 1'b0;
                if (r_init_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                    w_ready_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                w_ready_nxt = 1'b1;
                w_wr_en     = w_wr_req;
                w_rs_nxt    = w_rs_rd;
                w_rt_nxt    = w_rt_rd;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_ready    <= 1'b0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_cnt_nxt;
            r_ready    <= w_ready_nxt;
            r_rs_data  <= w_rs_nxt;
            r_rt_data  <= w_rt_nxt;
        end
    end

    // Storage has no reset of its own; the INIT sweep is what clears it
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_en) begin
                r_regs[r_init_cnt[ADDR_W-1:0]] <= '0;
            end else if (w_wr_en) begin
                r_regs[bus.writing_address] <= bus.write_inp;
            end
        end
    end

    assign bus.rs_data = r_rs_data;
    assign bus.rt_data = r_rt_data;
    assign bus.ready   = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// Module      : tb_reg_file
// Description : Directed scoreboard bench for reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] rt;
        int          tag;
    } exp_t;

    logic clk;
    logic rst_n;
    logic issue;
    logic issue_d;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) issue_d <= issue;

    // Monitor: a read issued before an edge is presented after it
    always @(negedge clk) begin
        if (issue_d === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: read result with no expected entry");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_cmp++;
                if (bus.rs_data !== e.rs) begin
                    n_bad++;
                    $display("FAIL rd%0d_rs: got %h want %h", e.tag, bus.rs_data, e.rs);
                end
                n_cmp++;
                if (bus.rt_data !== e.rt) begin
                    n_bad++;
                    $display("FAIL rd%0d_rt: got %h want %h", e.tag, bus.rt_data, e.rt);
                end
            end
        end
    end

    task automatic chk_ready(input logic want, input string name);
        n_cmp++;
        if (bus.ready !== want) begin
            n_bad++;
            $display("FAIL %s: ready got %b want %b", name, bus.ready, want);
        end
    endtask

    task automatic idle();
        bus.write = 1'b0;
        issue     = 1'b0;
        @(negedge clk);
    endtask

    // One cycle: optional write plus optional read with expected results
    task automatic cyc(input logic do_wr, input logic [4:0] wa, input logic [31:0] wd,
                       input logic do_rd, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] ea, input logic [31:0] eb, input int tag);
        exp_t e;
        bus.write           = do_wr;
        bus.writing_address = wa;
        bus.write_inp       = wd;
        bus.rs_add          = ra;
        bus.rt_add          = rb;
        issue               = do_rd;
        if (do_rd) begin
            e.rs = ea; e.rt = eb; e.tag = tag;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.write = 1'b0;
        issue     = 1'b0;
    endtask

    // Released at a negedge: ready must be low for 32 edges, then high
    task automatic init_sweep(input string name, input logic poke);
        for (int i = 0; i < 32; i++) begin
            chk_ready(1'b0, name);
            if (poke && i == 10)
                cyc(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
            else if (i == 20)
                cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd9, 32'd0, 32'd0, 100 + i);
            else
                idle();
        end
        chk_ready(1'b1, name);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        issue = 1'b0;
        rst_n = 1'b0;
        bus.write           = 1'b0;
        bus.writing_address = '0;
        bus.write_inp       = '0;
        bus.rs_add          = '0;
        bus.rt_add          = '0;
        @(negedge clk);
        @(negedge clk);
        chk_ready(1'b0, "rst_ready");
        n_cmp++;
        if (bus.rs_data !== 32'd0 || bus.rt_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_data: got %h/%h want 0/0", bus.rs_data, bus.rt_data);
        end
        rst_n = 1'b1;

        // Reset/init sweep with a dropped write to r3 at cycle 10
        init_sweep("init_ready", 1'b1);
        for (int i = 0; i < 32; i++)
            cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i), 32'd0, 32'd0, i);

        // Write then read back on both ports
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 40);

        // r0 protection
        cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 41);

        // Top register and independent ports
        cyc(1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd5, 32'hCAFEF00D, 32'hDEADBEEF, 42);

        // Same-cycle read and write
        cyc(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
`ifdef RF_BYPASS_EN
        cyc(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd5, 32'h22222222, 32'hDEADBEEF, 43);
`else
        cyc(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 5'd5, 32'h11111111, 32'hDEADBEEF, 43);
`endif
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 32'h22222222, 32'h22222222, 44);

        // Mid-run reset clears r9 through a fresh sweep
        cyc(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 45);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        init_sweep("rerun_ready", 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd5, 32'd0, 32'd0, 46);
        idle();
        idle();

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d entries left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
